// File: rtl/shift_reg_frame_if.sv
// Bus bundle for shift_reg_frame: manual-mode controls, frame start, register and lane outputs.
// Clock and reset are not part of the bundle.
interface shift_reg_frame_if #(
    parameter int unsigned N = 8,
    parameter int unsigned L = 1
) ();
    logic         en;
    logic [2:0]   mode;
    logic [L-1:0] si;
    logic [N-1:0] din;
    logic         start;
    logic [N-1:0] q;
    logic [L-1:0] so;
    logic         so_valid;
    logic         busy;
    logic         done;

    modport master (
        output en, mode, si, din, start,
        input  q, so, so_valid, busy, done
    );

    modport slave (
        input  en, mode, si, din, start,
        output q, so, so_valid, busy, done
    );
endinterface

// File: rtl/shift_reg_frame.sv
// N-bit shift register with an L-bit serial lane, seven manual modes and an autonomous
// frame serializer that streams a loaded word out as N/L lane beats.
module shift_reg_frame #(
    parameter int unsigned N         = 8,
    parameter int unsigned L         = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input logic              clk,
    input logic              rst,
    shift_reg_frame_if.slave bus
);
    localparam int unsigned   B        = N / L;
    localparam int unsigned   CW       = (B > 1) ? $clog2(B) : 1;
    localparam logic [CW-1:0] LastBeat = CW'(B - 1);

    localparam logic [2:0] ModeShr  = 3'b001;
    localparam logic [2:0] ModeShl  = 3'b010;
    localparam logic [2:0] ModeRor  = 3'b011;
    localparam logic [2:0] ModeRol  = 3'b100;
    localparam logic [2:0] ModeAsr  = 3'b101;
    localparam logic [2:0] ModeLoad = 3'b110;

    typedef enum logic {StIdle, StShift} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [L-1:0]  so_q, so_d;
    logic          so_valid_q, so_valid_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [L-1:0] lane_hi, lane_lo;
    logic [N-1:0] shl_val, shr_val, rol_val, ror_val, asr_val;

    // Widened concatenations keep every slice legal when L == N.
    assign lane_hi = q_q[N-1 -: L];
    assign lane_lo = q_q[L-1:0];
    assign shl_val = N'({q_q, bus.si});
    assign rol_val = N'({q_q, lane_hi});
    assign shr_val = N'({bus.si, q_q} >> L);
    assign ror_val = N'({lane_lo, q_q} >> L);
    assign asr_val = N'({{L{q_q[N-1]}}, q_q} >> L);

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        so_d       = so_q;
        so_valid_d = 1'b0;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    q_d     = bus.din;
                    cnt_d   = '0;
                    state_d = StShift;
                end else if (bus.en) begin
                    case (bus.mode)
                        ModeShr: begin
                            so_d = lane_lo;  q_d = shr_val;  so_valid_d = 1'b1;
                        end
                        ModeShl: begin
                            so_d = lane_hi;  q_d = shl_val;  so_valid_d = 1'b1;
                        end
                        ModeRor: begin
                            so_d = lane_lo;  q_d = ror_val;  so_valid_d = 1'b1;
                        end
                        ModeRol: begin
                            so_d = lane_hi;  q_d = rol_val;  so_valid_d = 1'b1;
                        end
                        ModeAsr: begin
                            so_d = lane_lo;  q_d = asr_val;  so_valid_d = 1'b1;
                        end
                        ModeLoad: q_d = bus.din;
                        default: ;
                    endcase
                end
            end
            StShift: begin
                so_d       = MSB_FIRST ? lane_hi : lane_lo;
                q_d        = MSB_FIRST ? shl_val : shr_val;
                so_valid_d = 1'b1;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == LastBeat) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            q_q        <= '0;
            so_q       <= '0;
            so_valid_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            so_q       <= so_d;
            so_valid_q <= so_valid_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.so       = so_q;
    assign bus.so_valid = so_valid_q;
    assign bus.busy     = (state_q == StShift);
    assign bus.done     = done_q;
endmodule

// File: doc/shift_reg_frame.md
# shift_reg_frame

Parametrised successor to the single-bit shift register. It provides an N-bit register with an L-bit serial lane and seven manual modes: hold, logical shift left/right, rotate left/right, arithmetic shift right and parallel load. It also has an autonomous frame serializer that loads a word and streams it out as N/L lane beats with busy/done handshaking. It sits between parallel datapaths and narrow serial links.

## Interface

Parameters:
- N, default 8: register width in bits; N >= 2.
- L, default 1: serial lane width; 1 <= L <= N, N % L == 0.
- MSB_FIRST, default 0: frame direction. 1 = shift left, outgoing lane is q[N-1:N-L]. 0 = shift right, outgoing lane is q[L-1:0].
- Derived: B = N/L beats per frame; counter width CW = max(1, clog2(B)).

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  enable for manual modes; ignored while busy.
- mode  in  3  000 hold, 001 SHR, 010 SHL, 011 ROR, 100 ROL, 101 ASR, 110 LOAD, 111 hold.
- si  in  L  serial input lane.
- din  in  N  parallel input.
- start  in  1  begin frame; sampled only in IDLE.
- q  out  N  register contents.
- so  out  L  registered serial output lane.
- so_valid  out  1  so holds a lane produced by the most recent edge.
- busy  out  1  frame in progress (state == SHIFT).
- done  out  1  one-cycle pulse coinciding with the last frame beat.

## Operation

- FSM states: IDLE and SHIFT. Beat counter cnt is CW bits wide.
- Priority per edge: rst > start (IDLE only) > SHIFT beat > manual mode (en=1) > hold.
- rst=1: q=0, so=0, so_valid=0, busy=0, done=0, cnt=0, state=IDLE. A reset mid-frame aborts the frame and produces no done.
- IDLE with start=1:
  - q<=din, cnt<=0, state<=SHIFT.
  - so is unchanged; so_valid<=0; done<=0.
  - mode and en are ignored on this edge.
- SHIFT, each edge:
  - Outgoing lane goes to so; so_valid<=1.
  - If MSB_FIRST=1: q<={q[N-L-1:0], si}. If MSB_FIRST=0: q<={si, q[N-1:L]}.
  - cnt<=cnt+1.
  - When cnt==B-1: done<=1 and state<=IDLE. Otherwise done<=0.
- In SHIFT, start, mode and en are ignored. start is not queued.
- IDLE manual modes, applied only when en=1 and start=0:
  - SHR: so<=q[L-1:0]; q<={si, q[N-1:L]}.
  - SHL: so<=q[N-1:N-L]; q<={q[N-L-1:0], si}.
  - ROR: so<=q[L-1:0]; q<={q[L-1:0], q[N-1:L]}.
  - ROL: so<=q[N-1:N-L]; q<={q[N-L-1:0], q[N-1:N-L]}.
  - ASR: so<=q[L-1:0]; q<={{L{q[N-1]}}, q[N-1:L]}.
  - For all five modes above, so_valid<=1.
  - LOAD: q<=din; so holds; so_valid<=0.
  - hold/111: q and so hold; so_valid<=0.
- With en=0, or in IDLE after a completed frame: q and so hold; so_valid<=0; done<=0.
- When L==N: shifts fully replace q with si, or with the sign fill for ASR.

## Timing

- start sampled at edge E0: q=din visible after E0, busy=1 after E0.
- Beats occur at edges E1..EB. so/so_valid are valid after each of these edges.
- done=1 after EB only. busy=0 after EB.
- busy is high for exactly B cycles. so_valid is high for exactly B cycles, lagging busy by one.
- start may be reasserted at edge EB+1 (back-to-back frames with no idle gap beyond one cycle). start held high is re-sampled at EB+1.
- Manual modes have single-cycle latency: q/so update at the edge that samples en/mode.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

- Reset: rst=1 with start=1, en=1, mode=001 for 3 edges -> q=0x00, so=0, so_valid=0, busy=0, done=0. After release with start=0 and en=0, everything holds.
- N=8, L=1: LOAD 0xA5, then SHR with si=1 -> q=0xD2, so=1, so_valid=1. Then ASR on q=0x80 -> q=0xC0, so=0.
- N=8, L=2: LOAD 0xA5, then ROL -> q=0x96, so=2'b10. Then ROR -> q=0xA5, so=2'b10.
- N=8, L=2, MSB_FIRST=1: start with din=0xB4, si=0.
  - so sequence is 10, 11, 01, 00 on E1..E4.
  - busy is high for 4 cycles; done pulses once after E4; final q=0x00.
  - mode=010, en=1 held throughout has no effect.
- N=8, L=1, MSB_FIRST=0: start with din=0x01.
  - Pulse start again at E3 -> ignored; frame still ends at E8 with so sequence 1,0,0,0,0,0,0,0.
  - Assert rst at E4 in a repeat run -> all outputs 0, no done pulse.
- L=N=8: start with din=0x3C -> one beat with so=0x3C; busy and done behave as B=1; back-to-back start at E2 is accepted.
